ysyx_22050854_opnd_fwd_stage: RTL
=================================

// Module: ysyx_22050854_opnd_fwd_stage
// PURPOSE
//  Registered ID->EX operand stage. Resolves rs1/rs2 against NUM_FWD bypass channels and the
//  regfile, selects ALU operands (reg/PC/imm/INST_BYTES/zero), and detects load-use hazards.
//  Holds the result in a valid/ready pipeline register feeding the ALU.
//  Successor to the combinational ALU source mux: parametrised width, channels and a 4-way src2.
// PARAMETERS
//  XLEN        64  operand/data width
//  PC_W        32  PC width; zero-extended to XLEN
//  NUM_FWD     3   bypass channels, index 0 = youngest = highest priority
//  INST_BYTES  4   constant for src2 sel 2 (link address)
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             synchronous, active-high reset
//  flush        in   1             kill in-flight and incoming op
//  in_valid     in   1             ID op valid
//  in_ready     out  1             stage accepts op this cycle
//  rs1_idx      in   5             source reg 1 index
//  rs2_idx      in   5             source reg 2 index
//  src1_sel     in   2             0 rs1, 1 PC, 2/3 zero
//  src2_sel     in   2             0 rs2, 1 imm, 2 INST_BYTES, 3 zero
//  pc           in   PC_W          op PC
//  imm          in   XLEN          sign-extended immediate
//  rf_rdata1    in   XLEN          regfile read port 1
//  rf_rdata2    in   XLEN          regfile read port 2
//  fwd_valid    in   NUM_FWD       channel carries a register write
//  fwd_pending  in   NUM_FWD       channel's value not yet available (load in flight)
//  fwd_rd       in   NUM_FWD*5     channel destination index, ch k at [5k+4:5k]
//  fwd_data     in   NUM_FWD*XLEN  channel write data
//  out_valid    out  1             registered op valid
//  out_ready    in   1             ALU consumes op
//  alu_src1     out  XLEN          registered operand 1
//  alu_src2     out  XLEN          registered operand 2
//  store_data   out  XLEN          registered resolved rs2 value regardless of src2_sel
//  stall_cnt    out  32            saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Resolve, per rs: idx==0 -> 0. Else first k ascending with fwd_valid[k] && fwd_rd[k]==idx
//    supplies fwd_data[k]. No match -> rf_rdata. Lower-priority matches are ignored.
//  - Hazard: winning match has fwd_pending[k]=1 and operand is used.
//    rs1 is used when src1_sel==0. rs2 is used when src2_sel==0 (store_data is not a use).
//    hazard = in_valid && (haz1 || haz2).
//  - in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational.
//  - Capture on in_valid && in_ready: out regs <- resolved values, out_valid <= 1, next edge.
//    Latency 1 cycle.
//  - Else if out_ready: out_valid <= 0. Otherwise all out regs hold (stable while stalled).
//  - flush: out_valid <= 0 next edge, no capture that cycle. Flush wins over capture/hold.
//  - stall_cnt += 1 each cycle with hazard && !flush; saturates at 32'hFFFF_FFFF.
//  - Reset: out_valid=0, alu_src1=alu_src2=store_data=0, stall_cnt=0.
//    Mid-op reset drops the held op.
//  - PC operand = {{(XLEN-PC_W){1'b0}}, pc}. INST_BYTES zero-extended to XLEN.
// STRUCTURE
//  - Shared header ysyx_22050854_defines.vh: SRC1_* / SRC2_* select encodings, REG_IDX_W=5.
//  - Sub-module ysyx_22050854_fwd_resolve #(XLEN,NUM_FWD), instantiated once per rs.
//    Output: {value, pending_hit}.
//  - Top: two resolvers, operand muxes, hazard logic, output register, stall counter.
// TESTING
//  1 rs1=5, rf_rdata1=0x11, no fwd, src1_sel=0, src2_sel=1, imm=-8 ->
//    next cycle out_valid=1, alu_src1=0x11, alu_src2=0xFFFF_FFFF_FFFF_FFF8.
//  2 rs2=7 hit on ch0 (0xAA) and ch2 (0xBB), src2_sel=0 -> alu_src2=store_data=0xAA.
//    rs=0 with ch0 rd=0 -> 0.
//  3 rs1=3 hit ch1 pending, src1_sel=0 -> in_ready=0 for 2 cycles, stall_cnt=2;
//    clear pending with fwd_data=0x55 -> captured alu_src1=0x55.
//    Same hit with src1_sel=1 -> no stall.
//  4 src1_sel=1, pc=0x8000_0004, src2_sel=2 -> alu_src1=0x0000_0000_8000_0004, alu_src2=4.
//  5 out_ready=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0;
//    assert flush -> out_valid=0 next edge, no capture.
//  6 rst during held op -> out_valid=0, all outputs 0, stall_cnt=0.
//    Saturation: preload near max -> holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/ysyx_22050854_opnd_fwd_stage_pkg.sv
// Shared encodings for the ID->EX operand stage: operand select codes and register index width.
package ysyx_22050854_opnd_fwd_stage_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    SRC1_RS1      = 2'd0,
    SRC1_PC       = 2'd1,
    SRC1_ZERO     = 2'd2,
    SRC1_ZERO_ALT = 2'd3
  } src1_sel_e;

  typedef enum logic [1:0] {
    SRC2_RS2        = 2'd0,
    SRC2_IMM        = 2'd1,
    SRC2_INST_BYTES = 2'd2,
    SRC2_ZERO       = 2'd3
  } src2_sel_e;

endpackage

// File: rtl/ysyx_22050854_fwd_resolve.sv
// Resolves one source register against the bypass channels and the regfile.
// result_o = {value, pending_hit}; channel 0 is the youngest and wins ties.
module ysyx_22050854_fwd_resolve
  import ysyx_22050854_opnd_fwd_stage_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_IDX_W-1:0]         idx_i,
  input  logic [XLEN-1:0]              rf_rdata_i,
  input  logic [NUM_FWD-1:0]           fwd_valid_i,
  input  logic [NUM_FWD-1:0]           fwd_pending_i,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data_i,
  output logic [XLEN:0]                result_o
);

  logic [XLEN-1:0] value;
  logic            pending_hit;
  logic            found;

  always_comb begin
    value       = rf_rdata_i;
    pending_hit = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!found && fwd_valid_i[k] && (fwd_rd_i[k*REG_IDX_W +: REG_IDX_W] == idx_i)) begin
        found       = 1'b1;
        value       = fwd_data_i[k*XLEN +: XLEN];
        pending_hit = fwd_pending_i[k];
      end
    end
    // x0 is hardwired; a channel writing x0 must never leak through or stall.
    if (idx_i == '0) begin
      value       = '0;
      pending_hit = 1'b0;
    end
  end

  assign result_o = {value, pending_hit};

endmodule

// File: rtl/ysyx_22050854_opnd_fwd_stage.sv
// Registered ID->EX operand stage: bypass resolution, ALU operand select, load-use
// hazard detection and a valid/ready output register feeding the ALU.
module ysyx_22050854_opnd_fwd_stage
  import ysyx_22050854_opnd_fwd_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PC_W       = 32,
  parameter int NUM_FWD    = 3,
  parameter int INST_BYTES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [REG_IDX_W-1:0]         rs1_idx_i,
  input  logic [REG_IDX_W-1:0]         rs2_idx_i,
  input  logic [1:0]                   src1_sel_i,
  input  logic [1:0]                   src2_sel_i,
  input  logic [PC_W-1:0]              pc_i,
  input  logic [XLEN-1:0]              imm_i,
  input  logic [XLEN-1:0]              rf_rdata1_i,
  input  logic [XLEN-1:0]              rf_rdata2_i,
  input  logic [NUM_FWD-1:0]           fwd_valid_i,
  input  logic [NUM_FWD-1:0]           fwd_pending_i,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [XLEN-1:0]              alu_src1_o,
  output logic [XLEN-1:0]              alu_src2_o,
  output logic [XLEN-1:0]              store_data_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam logic [XLEN-1:0] INST_BYTES_EXT = XLEN'(INST_BYTES);

  logic [XLEN:0]   res1, res2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_pend, rs2_pend;
  logic [XLEN-1:0] pc_ext;
  logic [XLEN-1:0] src1_mux, src2_mux;
  logic            hazard, capture;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  ysyx_22050854_fwd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_res_rs1 (
    .idx_i         (rs1_idx_i),
    .rf_rdata_i    (rf_rdata1_i),
    .fwd_valid_i   (fwd_valid_i),
    .fwd_pending_i (fwd_pending_i),
    .fwd_rd_i      (fwd_rd_i),
    .fwd_data_i    (fwd_data_i),
    .result_o      (res1)
  );

  ysyx_22050854_fwd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_res_rs2 (
    .idx_i         (rs2_idx_i),
    .rf_rdata_i    (rf_rdata2_i),
    .fwd_valid_i   (fwd_valid_i),
    .fwd_pending_i (fwd_pending_i),
    .fwd_rd_i      (fwd_rd_i),
    .fwd_data_i    (fwd_data_i),
    .result_o      (res2)
  );

  assign {rs1_val, rs1_pend} = res1;
  assign {rs2_val, rs2_pend} = res2;
  assign pc_ext = XLEN'(pc_i);

  always_comb begin
    case (src1_sel_i)
      SRC1_RS1: src1_mux = rs1_val;
      SRC1_PC:  src1_mux = pc_ext;
      default:  src1_mux = '0;
    endcase
  end

  always_comb begin
    case (src2_sel_i)
      SRC2_RS2:        src2_mux = rs2_val;
      SRC2_IMM:        src2_mux = imm_i;
      SRC2_INST_BYTES: src2_mux = INST_BYTES_EXT;
      default:         src2_mux = '0;
    endcase
  end

  // store_data alone does not stall: only ALU operand uses of a pending value do.
  assign hazard = in_valid_i &&
                  ((rs1_pend && (src1_sel_i == SRC1_RS1)) ||
                   (rs2_pend && (src2_sel_i == SRC2_RS2)));

  assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
  assign capture    = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    store_d     = store_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      src1_d      = src1_mux;
      src2_d      = src2_mux;
      store_d     = rs2_val;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      store_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      store_q     <= store_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign store_data_o = store_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
